// File: rtl/vga_pkg.sv
// Shared geometry and width constants for the frame-buffer scanout path.
// The frame buffer is the visible area downscaled by 2**SCALE_SHIFT in each axis.
package vga_pkg;
    localparam int H_ACTIVE    = 640;
    localparam int V_ACTIVE    = 480;
    localparam int SCALE_SHIFT = 2;
    localparam int FB_W        = H_ACTIVE >> SCALE_SHIFT;
    localparam int FB_H        = V_ACTIVE >> SCALE_SHIFT;
    localparam int FB_ADDR_W   = 16;
    localparam int FB_IDX_W    = FB_ADDR_W - 1;
    localparam int PIXEL_W     = 3;
    localparam int COORD_W     = 10;

    localparam logic SYNC_IDLE = 1'b1;

    // First blanking line, column zero: the one strobe per frame where buffers may swap
    localparam logic [COORD_W-1:0] FRAME_X = '0;
    localparam logic [COORD_W-1:0] FRAME_Y = COORD_W'(V_ACTIVE);

    typedef logic [FB_ADDR_W-1:0] fb_addr_t;
    typedef logic [PIXEL_W-1:0]   pixel_t;
    typedef logic [COORD_W-1:0]   coord_t;
endpackage

// File: rtl/framebuffer_scanout_if.sv
// Read port of the frame-buffer RAM: scanout is the master, the RAM the slave.
interface framebuffer_scanout_if
    import vga_pkg::*;
;
    logic     fb_rd_en;
    fb_addr_t fb_rd_addr;
    pixel_t   fb_rd_data;

    modport master (output fb_rd_en, output fb_rd_addr, input  fb_rd_data);
    modport slave  (input  fb_rd_en, input  fb_rd_addr, output fb_rd_data);
endinterface

// File: rtl/fb_addr_gen.sv
// Maps a screen coordinate to {buffer, fy*FB_W + fx} in the downscaled frame buffer.
// FB_W is fixed at 160, so the row multiply is two shifts and an add.
module fb_addr_gen
    import vga_pkg::*;
(
    input  logic     buf_sel,
    input  coord_t   x,
    input  coord_t   y,
    output fb_addr_t addr
);
    logic [FB_IDX_W-1:0] fx;
    logic [FB_IDX_W-1:0] fy;
    logic [FB_IDX_W-1:0] idx;

    always_comb begin
        fx   = FB_IDX_W'(x >> SCALE_SHIFT);
        fy   = FB_IDX_W'(y >> SCALE_SHIFT);
        idx  = (fy << 7) + (fy << 5) + fx;
        addr = {buf_sel, idx};
    end
endmodule

// File: rtl/framebuffer_scanout.sv
// Two-stage pixel pipeline: stage A issues the RAM read, stage B drives pixel and syncs.
// Front/back buffer swap is deferred to the frame boundary so a frame never tears.
module framebuffer_scanout
    import vga_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   pix_en,
    input  coord_t in_x,
    input  coord_t in_y,
    input  logic   in_display,
    input  logic   in_hsync,
    input  logic   in_vsync,
    framebuffer_scanout_if.master fb,
    input  logic   swap_req,
    output logic   swap_done,
    output logic   draw_buf,
    output logic   frame_start,
    output pixel_t pixel,
    output logic   hsync_out,
    output logic   vsync_out
);
    logic     disp_buf_q,     disp_buf_d;
    logic     swap_pending_q, swap_pending_d;
    logic     swap_done_q,    swap_done_d;
    logic     frame_start_q,  frame_start_d;
    logic     fb_rd_en_q,     fb_rd_en_d;
    fb_addr_t fb_rd_addr_q,   fb_rd_addr_d;
    logic     disp_a_q,       disp_a_d;
    logic     hs_a_q,         hs_a_d;
    logic     vs_a_q,         vs_a_d;
    pixel_t   pixel_q,        pixel_d;
    logic     hsync_q,        hsync_d;
    logic     vsync_q,        vsync_d;

    fb_addr_t addr_calc;
    logic     boundary;

    fb_addr_gen u_addr_gen (
        .buf_sel (disp_buf_q),
        .x       (in_x),
        .y       (in_y),
        .addr    (addr_calc)
    );

    always_comb begin
        disp_buf_d     = disp_buf_q;
        swap_pending_d = swap_pending_q;
        swap_done_d    = 1'b0;
        fb_rd_en_d     = 1'b0;
        fb_rd_addr_d   = fb_rd_addr_q;
        disp_a_d       = disp_a_q;
        hs_a_d         = hs_a_q;
        vs_a_d         = vs_a_q;
        pixel_d        = pixel_q;
        hsync_d        = hsync_q;
        vsync_d        = vsync_q;

        boundary      = pix_en && (in_x == FRAME_X) && (in_y == FRAME_Y);
        frame_start_d = boundary;

        if (pix_en) begin
            fb_rd_en_d = in_display;
            if (in_display) begin
                fb_rd_addr_d = addr_calc;
            end
            disp_a_d = in_display;
            hs_a_d   = in_hsync;
            vs_a_d   = in_vsync;
            // RAM data for the read issued last strobe has been stable for at least one clk
            pixel_d  = disp_a_q ? fb.fb_rd_data : '0;
            hsync_d  = hs_a_q;
            vsync_d  = vs_a_q;
        end

        if (boundary && (swap_pending_q || swap_req)) begin
            disp_buf_d     = ~disp_buf_q;
            swap_done_d    = 1'b1;
            swap_pending_d = 1'b0;
        end else if (swap_req) begin
            swap_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_buf_q     <= 1'b0;
            swap_pending_q <= 1'b0;
            swap_done_q    <= 1'b0;
            frame_start_q  <= 1'b0;
            fb_rd_en_q     <= 1'b0;
            fb_rd_addr_q   <= '0;
            disp_a_q       <= 1'b0;
            hs_a_q         <= SYNC_IDLE;
            vs_a_q         <= SYNC_IDLE;
            pixel_q        <= '0;
            hsync_q        <= SYNC_IDLE;
            vsync_q        <= SYNC_IDLE;
        end else begin
            disp_buf_q     <= disp_buf_d;
            swap_pending_q <= swap_pending_d;
            swap_done_q    <= swap_done_d;
            frame_start_q  <= frame_start_d;
            fb_rd_en_q     <= fb_rd_en_d;
            fb_rd_addr_q   <= fb_rd_addr_d;
            disp_a_q       <= disp_a_d;
            hs_a_q         <= hs_a_d;
            vs_a_q         <= vs_a_d;
            pixel_q        <= pixel_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
        end
    end

    assign fb.fb_rd_en   = fb_rd_en_q;
    assign fb.fb_rd_addr = fb_rd_addr_q;
    assign swap_done     = swap_done_q;
    assign draw_buf      = ~disp_buf_q;
    assign frame_start   = frame_start_q;
    assign pixel         = pixel_q;
    assign hsync_out     = hsync_q;
    assign vsync_out     = vsync_q;
endmodule

// File: tb/tb_framebuffer_scanout.sv
// Directed bench for framebuffer_scanout; the RAM model returns the low 3 address bits.
module tb_framebuffer_scanout;
    import vga_pkg::*;

    logic   clk = 1'b0;
    logic   rst;
    logic   pix_en;
    coord_t in_x;
    coord_t in_y;
    logic   in_display;
    logic   in_hsync;
    logic   in_vsync;
    logic   swap_req;
    logic   swap_done;
    logic   draw_buf;
    logic   frame_start;
    pixel_t pixel;
    logic   hsync_out;
    logic   vsync_out;

    int n_checks = 0;
    int n_errors = 0;
    int rd_cnt   = 0;
    int sd_cnt   = 0;
    int fs_cnt   = 0;

    framebuffer_scanout_if fb_bus ();

    framebuffer_scanout dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_display  (in_display),
        .in_hsync    (in_hsync),
        .in_vsync    (in_vsync),
        .fb          (fb_bus.master),
        .swap_req    (swap_req),
        .swap_done   (swap_done),
        .draw_buf    (draw_buf),
        .frame_start (frame_start),
        .pixel       (pixel),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) fb_bus.fb_rd_data <= '0;
        else if (fb_bus.fb_rd_en) fb_bus.fb_rd_data <= fb_bus.fb_rd_addr[2:0];
    end

    always @(posedge clk) begin
        if (fb_bus.fb_rd_en) rd_cnt <= rd_cnt + 1;
        if (swap_done)       sd_cnt <= sd_cnt + 1;
        if (frame_start)     fs_cnt <= fs_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // One pix_en strobe spanning two clks; returns on the falling edge after the strobe edge
    task automatic strobe(input int x, input int y, input logic disp, input logic hs,
                          input logic vs, input logic sw);
        @(negedge clk);
        in_x       = coord_t'(x);
        in_y       = coord_t'(y);
        in_display = disp;
        in_hsync   = hs;
        in_vsync   = vs;
        swap_req   = sw;
        pix_en     = 1'b1;
        @(negedge clk);
        pix_en     = 1'b0;
        swap_req   = 1'b0;
    endtask

    function automatic logic [31:0] ram_val(input int x, input int y);
        int idx;
        idx = (y / 4) * 160 + (x / 4);
        return 32'(idx % 8);
    endfunction

    initial begin
        int   sd0;
        int   fs0;
        int   prev_x;
        logic prev_disp;
        logic prev_hs;

        rst = 1'b1; pix_en = 1'b0; in_x = '0; in_y = '0;
        in_display = 1'b0; in_hsync = 1'b1; in_vsync = 1'b1; swap_req = 1'b0;

        // Reset: strobes with display active must not issue reads
        strobe(5, 9, 1'b1, 1'b1, 1'b1, 1'b0);
        strobe(8, 9, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("rst_pixel", 32'(pixel), 32'd0);
        chk("rst_hsync", 32'(hsync_out), 32'd1);
        chk("rst_vsync", 32'(vsync_out), 32'd1);
        chk("rst_draw_buf", 32'(draw_buf), 32'd1);
        chk("rst_rd_addr", 32'(fb_bus.fb_rd_addr), 32'd0);
        chk("rst_swap_done", 32'(swap_done), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_rd_cnt", 32'(rd_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Address map
        strobe(5, 9, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("addr_5_9", 32'(fb_bus.fb_rd_addr), 32'h0141);
        chk("rd_en_5_9", 32'(fb_bus.fb_rd_en), 32'd1);
        strobe(639, 479, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("addr_639_479", 32'(fb_bus.fb_rd_addr), 32'h4AFF);
        chk("rd_cnt_one", 32'(rd_cnt), 32'd1);
        chk("pix_5_9", 32'(pixel), 32'd1);

        // Line sweep: pixel and hsync both lag their inputs by one strobe after stage A
        prev_x = 639; prev_disp = 1'b1; prev_hs = 1'b1;
        for (int x = 0; x < 48; x++) begin
            logic disp;
            logic hs;
            disp = (x < 40);
            hs   = !(x >= 20 && x < 28);
            strobe(x, 10, disp, hs, 1'b1, 1'b0);
            if (x == 0) chk("pix_639_479", 32'(pixel), 32'd7);
            else chk($sformatf("sweep_pix_x%0d", prev_x), 32'(pixel),
                     prev_disp ? ram_val(prev_x, 10) : 32'd0);
            chk($sformatf("sweep_hs_x%0d", prev_x), 32'(hsync_out), 32'(prev_hs));
            prev_x = x; prev_disp = disp; prev_hs = hs;
        end
        chk("sweep_vsync", 32'(vsync_out), 32'd1);

        // Three requests in one frame -> one deferred swap
        sd0 = sd_cnt; fs0 = fs_cnt;
        strobe(0, 100, 1'b1, 1'b1, 1'b1, 1'b1);
        strobe(100, 200, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("midframe_draw_buf", 32'(draw_buf), 32'd1);
        chk("midframe_swap_done", 32'(swap_done), 32'd0);
        strobe(200, 300, 1'b1, 1'b1, 1'b1, 1'b1);
        strobe(4, 479, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("pre_boundary_draw_buf", 32'(draw_buf), 32'd1);
        strobe(0, 480, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("swap_done_pulse", 32'(swap_done), 32'd1);
        chk("frame_start_pulse", 32'(frame_start), 32'd1);
        chk("swap_draw_buf", 32'(draw_buf), 32'd0);
        strobe(8, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("swap_done_cleared", 32'(swap_done), 32'd0);
        chk("addr_buf1_8_0", 32'(fb_bus.fb_rd_addr), 32'h8002);
        chk("one_swap", 32'(sd_cnt - sd0), 32'd1);
        chk("one_frame_start", 32'(fs_cnt - fs0), 32'd1);
        strobe(0, 480, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("no_extra_swap_done", 32'(swap_done), 32'd0);
        chk("no_extra_draw_buf", 32'(draw_buf), 32'd0);

        // Request coincident with the boundary strobe
        strobe(0, 480, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("coinc_swap_done", 32'(swap_done), 32'd1);
        chk("coinc_draw_buf", 32'(draw_buf), 32'd1);
        strobe(0, 480, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("coinc_no_pending", 32'(swap_done), 32'd0);
        chk("coinc_no_pending_buf", 32'(draw_buf), 32'd1);

        // Reset mid-line with a swap pending and buffer 1 displayed
        strobe(0, 100, 1'b1, 1'b1, 1'b1, 1'b1);
        strobe(0, 480, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("pre_rst_draw_buf", 32'(draw_buf), 32'd0);
        strobe(0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        strobe(296, 50, 1'b1, 1'b0, 1'b0, 1'b0);
        strobe(300, 50, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("pre_rst_pix", 32'(pixel), 32'd2);
        chk("pre_rst_hsync", 32'(hsync_out), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_pixel", 32'(pixel), 32'd0);
        chk("mid_rst_hsync", 32'(hsync_out), 32'd1);
        chk("mid_rst_vsync", 32'(vsync_out), 32'd1);
        chk("mid_rst_draw_buf", 32'(draw_buf), 32'd1);
        chk("mid_rst_rd_addr", 32'(fb_bus.fb_rd_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        strobe(304, 50, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("post_rst_addr", 32'(fb_bus.fb_rd_addr), 32'd1996);
        strobe(308, 50, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("post_rst_pix", 32'(pixel), 32'd4);
        chk("post_rst_hsync", 32'(hsync_out), 32'd0);
        strobe(0, 480, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("post_rst_no_swap", 32'(swap_done), 32'd0);
        chk("post_rst_frame_start", 32'(frame_start), 32'd1);
        chk("post_rst_draw_buf", 32'(draw_buf), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
